// File: rtl/lp_filter_pkg.sv
// Shared definitions for the low-pass filter engine.
//   state_e      : scheduler FSM states.
//   ch_idx_bits  : index width for n entries (never below 1).
//   stage_update : one exponential-smoothing step, also used by the single-channel filter.
package lp_filter_pkg;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    function automatic int unsigned ch_idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Callers pass operands zero-extended to 64 bits and truncate the result to their state width.
    // On init the state is preloaded so that the stage output equals x.
    function automatic logic [63:0] stage_update(input logic [63:0] st, input logic [63:0] x,
                                                 input int unsigned shift, input logic init);
        if (init) begin
            return x << shift;
        end
        return st - (st >> shift) + x;
    endfunction

endpackage

// File: rtl/lp_filter_sched_if.sv
// Sample/result bus of the filter scheduler.
//   master : drives IN_VALID / IN_VALUE, observes results.
//   slave  : the engine; drives OUT_VALID, OUT_CHANNEL, OUT_VALUE, BUSY, OVERRUN.
interface lp_filter_sched_if
    import lp_filter_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned DATA_BITS = 28
);
    localparam int unsigned CH_BITS = ch_idx_bits(CHANNELS);

    logic [CHANNELS-1:0]           IN_VALID;
    logic [CHANNELS*DATA_BITS-1:0] IN_VALUE;
    logic                          OUT_VALID;
    logic [CH_BITS-1:0]            OUT_CHANNEL;
    logic [DATA_BITS-1:0]          OUT_VALUE;
    logic                          BUSY;
    logic [CHANNELS-1:0]           OVERRUN;

    modport master (
        output IN_VALID, IN_VALUE,
        input  OUT_VALID, OUT_CHANNEL, OUT_VALUE, BUSY, OVERRUN
    );

    modport slave (
        input  IN_VALID, IN_VALUE,
        output OUT_VALID, OUT_CHANNEL, OUT_VALUE, BUSY, OVERRUN
    );

endinterface

// File: rtl/lp_stage_alu.sv
// Combinational single-stage smoothing update.
//   st      : current stage state (DATA_BITS+SHIFT_BITS)
//   x       : stage input sample
//   init    : preload state from x instead of smoothing
//   st_next : updated state
//   y       : stage output (st_next >> SHIFT_BITS)
module lp_stage_alu
    import lp_filter_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 28,
    parameter int unsigned SHIFT_BITS = 5
) (
    input  logic [DATA_BITS+SHIFT_BITS-1:0] st,
    input  logic [DATA_BITS-1:0]            x,
    input  logic                            init,
    output logic [DATA_BITS+SHIFT_BITS-1:0] st_next,
    output logic [DATA_BITS-1:0]            y
);
    localparam int unsigned ST_BITS = DATA_BITS + SHIFT_BITS;

    always_comb begin
        st_next = ST_BITS'(stage_update(64'(st), 64'(x), SHIFT_BITS, init));
        y       = st_next[ST_BITS-1:SHIFT_BITS];
    end

endmodule

// File: rtl/lp_filter_sched.sv
// Time-multiplexed cascaded low-pass filter with round-robin sample scheduling.
//   CLK, RESET (sync, active-high), CE (clock enable)
//   bus.IN_VALID/IN_VALUE      : per-channel sample strobes and flattened samples
//   bus.OUT_VALID/CHANNEL/VALUE: tagged one-cycle result
//   bus.BUSY                   : engine running or samples pending
//   bus.OVERRUN                : sticky per-channel lost-sample flags
module lp_filter_sched
    import lp_filter_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 28,
    parameter int unsigned SHIFT_BITS  = 5,
    parameter int unsigned STAGE_COUNT = 2,
    parameter int unsigned CHANNELS    = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CE,
    lp_filter_sched_if.slave  bus
);
    localparam int unsigned ST_BITS = DATA_BITS + SHIFT_BITS;
    localparam int unsigned STAGES  = (STAGE_COUNT == 0) ? 1 : STAGE_COUNT;
    localparam int unsigned CH_BITS = ch_idx_bits(CHANNELS);
    localparam int unsigned SG_BITS = ch_idx_bits(STAGES);
    localparam logic [SG_BITS-1:0] LAST_STAGE = SG_BITS'(STAGES - 1);
    localparam logic [CH_BITS-1:0] LAST_CH    = CH_BITS'(CHANNELS - 1);

    state_e               state_q;
    logic [CH_BITS-1:0]   ch_q;
    logic [CH_BITS-1:0]   rr_q;
    logic [SG_BITS-1:0]   stage_q;
    logic [DATA_BITS-1:0] x_q;
    logic [CHANNELS-1:0]  pend_q;
    logic [CHANNELS-1:0]  init_q;
    logic [CHANNELS-1:0]  overrun_q;
    logic [DATA_BITS-1:0] pend_val_q [CHANNELS];
    logic [ST_BITS-1:0]   st_q       [CHANNELS][STAGES];
    logic                 out_valid_q;
    logic [CH_BITS-1:0]   out_ch_q;
    logic [DATA_BITS-1:0] out_val_q;

    logic                 grant_any;
    logic                 grant;
    logic [CH_BITS-1:0]   grant_ch;
    logic [ST_BITS-1:0]   alu_st;
    logic [DATA_BITS-1:0] alu_y;

    // Round-robin search: first pending channel at or after rr_q, wrapping.
    always_comb begin
        logic [CH_BITS:0] sum;
        grant_any = 1'b0;
        grant_ch  = '0;
        sum       = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            sum = {1'b0, rr_q} + (CH_BITS+1)'(i);
            if (sum >= (CH_BITS+1)'(CHANNELS)) begin
                sum = sum - (CH_BITS+1)'(CHANNELS);
            end
            if (!grant_any && pend_q[sum[CH_BITS-1:0]]) begin
                grant_any = 1'b1;
                grant_ch  = sum[CH_BITS-1:0];
            end
        end
    end

    assign grant = (state_q == StIdle) && grant_any;

    lp_stage_alu #(
        .DATA_BITS  (DATA_BITS),
        .SHIFT_BITS (SHIFT_BITS)
    ) u_alu (
        .st      (st_q[ch_q][stage_q]),
        .x       (x_q),
        .init    (~init_q[ch_q]),
        .st_next (alu_st),
        .y       (alu_y)
    );

    // Filter state and pending samples are deliberately left out of reset; init_q covers them.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            rr_q        <= '0;
            stage_q     <= '0;
            x_q         <= '0;
            pend_q      <= '0;
            init_q      <= '0;
            overrun_q   <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_val_q   <= '0;
        end else if (CE) begin
            out_valid_q <= 1'b0;

            // A strobe on the grant edge queues behind the sample being granted.
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (bus.IN_VALID[c]) begin
                    pend_val_q[c] <= bus.IN_VALUE[c*DATA_BITS +: DATA_BITS];
                    pend_q[c]     <= 1'b1;
                    if (pend_q[c] && !(grant && grant_ch == CH_BITS'(c))) begin
                        overrun_q[c] <= 1'b1;
                    end
                end else if (grant && grant_ch == CH_BITS'(c)) begin
                    pend_q[c] <= 1'b0;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        ch_q    <= grant_ch;
                        x_q     <= pend_val_q[grant_ch];
                        rr_q    <= (grant_ch == LAST_CH) ? '0 : grant_ch + 1'b1;
                        stage_q <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (STAGE_COUNT != 0) begin
                        st_q[ch_q][stage_q] <= alu_st;
                        x_q                 <= alu_y;
                    end
                    if (stage_q == LAST_STAGE) begin
                        out_valid_q  <= 1'b1;
                        out_ch_q     <= ch_q;
                        out_val_q    <= (STAGE_COUNT == 0) ? x_q : alu_y;
                        init_q[ch_q] <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        stage_q <= stage_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.OUT_VALID   = out_valid_q;
    assign bus.OUT_CHANNEL = out_ch_q;
    assign bus.OUT_VALUE   = out_val_q;
    assign bus.BUSY        = (state_q != StIdle) || (|pend_q);
    assign bus.OVERRUN     = overrun_q;

endmodule

// File: tb/tb_lp_filter_sched.sv
// Directed self-checking bench for lp_filter_sched (DATA_BITS=28, SHIFT_BITS=5, 2 stages, 4 ch).
module tb_lp_filter_sched;
    localparam int unsigned DB = 28;
    localparam int unsigned SB = 5;
    localparam int unsigned SC = 2;
    localparam int unsigned CH = 4;

    logic CLK = 1'b0;
    logic RESET;
    logic CE;
    int   checks = 0;
    int   passed = 0;

    lp_filter_sched_if #(.CHANNELS(CH), .DATA_BITS(DB)) bus ();

    lp_filter_sched #(
        .DATA_BITS   (DB),
        .SHIFT_BITS  (SB),
        .STAGE_COUNT (SC),
        .CHANNELS    (CH)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .CE    (CE),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // All tasks start and end on a falling edge.
    task automatic do_reset();
        RESET        = 1'b1;
        CE           = 1'b1;
        bus.IN_VALID = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic send(input int ch, input logic [DB-1:0] val);
        bus.IN_VALID[ch]          = 1'b1;
        bus.IN_VALUE[ch*DB +: DB] = val;
        @(negedge CLK);
        bus.IN_VALID = '0;
    endtask

    // lat = falling edges until OUT_VALID seen; 0 means timed out.
    task automatic wait_out(output int lat, output logic [1:0] ch, output logic [DB-1:0] val);
        lat = 0;
        ch  = '0;
        val = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (bus.OUT_VALID === 1'b1) begin
                lat = k;
                ch  = bus.OUT_CHANNEL;
                val = bus.OUT_VALUE;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.OUT_VALID !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.OUT_VALID); else passed++;
        checks++; if (bus.OUT_CHANNEL !== 2'd0) $display("FAIL reset_chan got %0d want 0", bus.OUT_CHANNEL); else passed++;
        checks++; if (bus.OUT_VALUE !== 28'd0) $display("FAIL reset_value got %0d want 0", bus.OUT_VALUE); else passed++;
        checks++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.BUSY); else passed++;
        checks++; if (bus.OVERRUN !== 4'b0) $display("FAIL reset_overrun got %b want 0000", bus.OVERRUN); else passed++;
    endtask

    task automatic test_preload();
        int lat; logic [1:0] ch; logic [DB-1:0] val;
        send(0, 28'd109377165);
        checks++; if (bus.BUSY !== 1'b1) $display("FAIL preload_busy got %0b want 1", bus.BUSY); else passed++;
        wait_out(lat, ch, val);
        checks++; if (lat !== 3) $display("FAIL preload_latency got %0d want 3", lat); else passed++;
        checks++; if (ch !== 2'd0) $display("FAIL preload_chan got %0d want 0", ch); else passed++;
        checks++; if (val !== 28'd109377165) $display("FAIL preload_value got %0d want 109377165", val); else passed++;
    endtask

    task automatic test_converge();
        int lat; logic [1:0] ch; logic [DB-1:0] val; int timeouts; int diff;
        timeouts = 0;
        send(0, 28'd54688582);
        wait_out(lat, ch, val);
        checks++; if (val !== 28'd109323758) $display("FAIL step_value got %0d want 109323758", val); else passed++;
        for (int i = 0; i < 2000; i++) begin
            send(0, 28'd54688582);
            wait_out(lat, ch, val);
            if (lat == 0) timeouts++;
        end
        diff = int'(val) - 54688582;
        checks++; if (timeouts != 0) $display("FAIL converge_timeouts got %0d want 0", timeouts); else passed++;
        checks++; if (diff > 1 || diff < -1) $display("FAIL converge_value got %0d want 54688582+-1", val); else passed++;
    endtask

    task automatic test_all_channels();
        int lat; logic [1:0] ch; logic [DB-1:0] val;
        do_reset();
        bus.IN_VALID = 4'hF;
        for (int c = 0; c < 4; c++) bus.IN_VALUE[c*DB +: DB] = DB'(100 * (c + 1));
        @(negedge CLK);
        bus.IN_VALID = '0;
        for (int i = 0; i < 4; i++) begin
            wait_out(lat, ch, val);
            checks++; if (lat !== 3) $display("FAIL all_spacing[%0d] got %0d want 3", i, lat); else passed++;
            checks++; if (ch !== 2'(i)) $display("FAIL all_chan[%0d] got %0d want %0d", i, ch, i); else passed++;
            checks++; if (val !== DB'(100 * (i + 1))) $display("FAIL all_value[%0d] got %0d want %0d", i, val, 100 * (i + 1)); else passed++;
        end
        checks++; if (bus.OVERRUN !== 4'b0) $display("FAIL all_overrun got %b want 0000", bus.OVERRUN); else passed++;
        checks++; if (bus.BUSY !== 1'b0) $display("FAIL all_busy_done got %0b want 0", bus.BUSY); else passed++;
    endtask

    task automatic test_overrun();
        int lat; logic [1:0] ch; logic [DB-1:0] val;
        do_reset();
        bus.IN_VALID             = 4'b0101;
        bus.IN_VALUE[0*DB +: DB] = 28'd50;
        bus.IN_VALUE[2*DB +: DB] = 28'd5;
        @(negedge CLK);
        bus.IN_VALID             = 4'b0100;
        bus.IN_VALUE[2*DB +: DB] = 28'd7;
        @(negedge CLK);
        bus.IN_VALID = '0;
        wait_out(lat, ch, val);
        checks++; if (ch !== 2'd0 || val !== 28'd50) $display("FAIL ovr_first got ch%0d=%0d want ch0=50", ch, val); else passed++;
        wait_out(lat, ch, val);
        checks++; if (ch !== 2'd2) $display("FAIL ovr_chan got %0d want 2", ch); else passed++;
        checks++; if (val !== 28'd7) $display("FAIL ovr_value got %0d want 7", val); else passed++;
        checks++; if (bus.OVERRUN !== 4'b0100) $display("FAIL ovr_flag got %b want 0100", bus.OVERRUN); else passed++;
        do_reset();
        checks++; if (bus.OVERRUN !== 4'b0000) $display("FAIL ovr_cleared got %b want 0000", bus.OVERRUN); else passed++;
    endtask

    task automatic test_grant_collision();
        int lat; logic [1:0] ch; logic [DB-1:0] val;
        do_reset();
        bus.IN_VALID[1]          = 1'b1;
        bus.IN_VALUE[1*DB +: DB] = 28'd3200;
        @(negedge CLK);
        bus.IN_VALUE[1*DB +: DB] = 28'd6400;
        @(negedge CLK);
        bus.IN_VALID = '0;
        wait_out(lat, ch, val);
        checks++; if (ch !== 2'd1 || val !== 28'd3200) $display("FAIL coll_old got ch%0d=%0d want ch1=3200", ch, val); else passed++;
        wait_out(lat, ch, val);
        checks++; if (lat !== 3) $display("FAIL coll_spacing got %0d want 3", lat); else passed++;
        checks++; if (val !== 28'd3203) $display("FAIL coll_new got %0d want 3203", val); else passed++;
        checks++; if (bus.OVERRUN !== 4'b0) $display("FAIL coll_overrun got %b want 0000", bus.OVERRUN); else passed++;
    endtask

    task automatic test_ce_stall();
        int lat; logic [1:0] ch; logic [DB-1:0] val; int highs;
        do_reset();
        send(3, 28'd1000);
        wait_out(lat, ch, val);
        send(3, 28'd5000);
        @(negedge CLK);
        CE    = 1'b0;
        highs = 0;
        repeat (10) begin
            @(negedge CLK);
            if (bus.OUT_VALID !== 1'b0) highs++;
        end
        checks++; if (highs != 0) $display("FAIL ce_frozen_pulses got %0d want 0", highs); else passed++;
        CE = 1'b1;
        wait_out(lat, ch, val);
        checks++; if (lat !== 2) $display("FAIL ce_resume_latency got %0d want 2", lat); else passed++;
        checks++; if (ch !== 2'd3 || val !== 28'd1003) $display("FAIL ce_result got ch%0d=%0d want ch3=1003", ch, val); else passed++;
        CE = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (bus.OUT_VALID !== 1'b1) $display("FAIL ce_valid_hold got %0b want 1", bus.OUT_VALID); else passed++;
        CE = 1'b1;
        @(negedge CLK);
        checks++; if (bus.OUT_VALID !== 1'b0) $display("FAIL ce_valid_clear got %0b want 0", bus.OUT_VALID); else passed++;
        highs = 0;
        repeat (8) begin
            @(negedge CLK);
            if (bus.OUT_VALID !== 1'b0) highs++;
        end
        checks++; if (highs != 0) $display("FAIL ce_extra_pulses got %0d want 0", highs); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [1:0] ch; logic [DB-1:0] val; int highs;
        do_reset();
        send(0, 28'd500);
        wait_out(lat, ch, val);
        send(0, 28'd9000);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        highs = 0;
        repeat (10) begin
            @(negedge CLK);
            if (bus.OUT_VALID !== 1'b0) highs++;
        end
        checks++; if (highs != 0) $display("FAIL rst_run_pulses got %0d want 0", highs); else passed++;
        checks++; if (bus.BUSY !== 1'b0) $display("FAIL rst_run_busy got %0b want 0", bus.BUSY); else passed++;
        send(0, 28'd1000);
        wait_out(lat, ch, val);
        checks++; if (lat !== 3) $display("FAIL rst_run_latency got %0d want 3", lat); else passed++;
        checks++; if (val !== 28'd1000) $display("FAIL rst_run_preload got %0d want 1000", val); else passed++;
    endtask

    initial begin
        RESET        = 1'b1;
        CE           = 1'b1;
        bus.IN_VALID = '0;
        bus.IN_VALUE = '0;
        @(negedge CLK);
        test_reset();
        test_preload();
        test_converge();
        test_all_channels();
        test_overrun();
        test_grant_collision();
        test_ce_stall();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lp_filter_sched.md
Name: lp_filter_sched

Overview:
- Time-multiplexed low-pass filter engine and scheduler for the multi-channel sensor front end.
- CHANNELS period/frequency measurement channels share one cascaded exponential-smoothing datapath.
- Filter state for every channel and stage lives in a local register file.
- A round-robin scheduler queues incoming samples, runs each one through STAGE_COUNT stages, one stage per cycle, and emits a tagged result stream.

Parameters:
- DATA_BITS, 28: input/output sample width (unsigned).
- SHIFT_BITS, 5: smoothing shift; per-stage coefficient is 2^-SHIFT_BITS.
- STAGE_COUNT, 2: cascaded stages, 0..8; 0 = pass-through.
- CHANNELS, 4: number of requesting channels, 1..16.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous reset, active-high.
- CE  in  1  clock enable; when 0 all state holds, including OUT_VALID.
- IN_VALID  in  CHANNELS  per-channel new-sample strobe.
- IN_VALUE  in  CHANNELS*DATA_BITS  flattened samples; channel c at bits [c*DATA_BITS +: DATA_BITS].
- OUT_VALID  out  1  one-cycle result strobe.
- OUT_CHANNEL  out  $clog2(CHANNELS), min 1  channel of the current result.
- OUT_VALUE  out  DATA_BITS  filtered result.
- BUSY  out  1  FSM not IDLE, or any sample pending.
- OVERRUN  out  CHANNELS  sticky: a pending sample was overwritten before it was served.

Behaviour:
- Reset (RESET=1 at a CLK edge, regardless of CE):
  - OUT_VALID=0, OUT_CHANNEL=0, OUT_VALUE=0, BUSY=0, OVERRUN=0.
  - Pending bits and per-channel init flags cleared; RR pointer=0; FSM=IDLE.
  - Filter state is not cleared (init flag handles it).
- Capture (CE=1): IN_VALID[c] latches IN_VALUE slice c into pend_val[c] and sets pend[c].
  - If pend[c] was already set and is not being granted this edge: overwrite and set OVERRUN[c].
  - IN_VALID[c] on the same edge c is granted: the granted copy is the old sample; the new one becomes pending; no overrun.
- Arbitration, in IDLE with any pend set: grant the first set channel searching from RR pointer upward with wrap.
  - On grant: latch channel and sample, clear pend, RR pointer = granted+1 mod CHANNELS; go to RUN with stage=0.
- RUN: one stage per cycle; runs max(STAGE_COUNT,1) cycles.
  - Stage input x is the granted sample for stage 0, otherwise the previous stage output.
  - State st is DATA_BITS+SHIFT_BITS wide, unsigned.
  - Update: st' = st - (st >> SHIFT_BITS) + x; stage output = st' >> SHIFT_BITS.
  - No overflow is possible.
- First sample per channel (init flag=0): every stage is preloaded with st' = x << SHIFT_BITS, so output = x; then the flag is set.
- STAGE_COUNT=0: a single RUN cycle with output = sample; no state.
- Last RUN edge: register OUT_VALUE and OUT_CHANNEL, pulse OUT_VALID, return to IDLE. The next grant can occur on the following edge.
- Latency: IN_VALID edge E0, grant at E1, OUT_VALID high after edge E0+1+max(STAGE_COUNT,1).
- Throughput: one sample per max(STAGE_COUNT,1)+1 cycles aggregate.
- CE=0 mid-RUN: FSM, stage counter, state and outputs freeze; OUT_VALID stays at its value; resume on CE=1.
  - Implementations must gate the OUT_VALID clear with CE.
- RESET mid-RUN: the in-flight sample is dropped; no OUT_VALID; state is re-initialised on the next sample via the init flag.

Decomposition:
- Package lp_filter_pkg: FSM state enum (IDLE, RUN); a function computing the channel index width; a function computing one stage update, shared with the existing single-channel filter.
- Sub-module lp_stage_alu (combinational): st, x, init → st', y.
- Arbiter and FSM stay in the top level.

Test Plan:
Configuration: DATA_BITS=28, SHIFT_BITS=5, STAGE_COUNT=2, CHANNELS=4, CE=1 unless stated.
1. Reset, then IN_VALID[0] with 109377165 → OUT_VALID 3 cycles later; OUT_CHANNEL=0; OUT_VALUE=109377165 (preload).
2. Then ch0 with 54688582 → OUT_VALUE=109323758 (stage0 output 107668146); repeat 2000 times → converges to within 1 of 54688582.
3. All four IN_VALID in one cycle with values 100,200,300,400 (first samples) → four OUT_VALID pulses spaced 3 cycles apart; channels 0,1,2,3; values 100..400; OVERRUN=0.
4. Ch2 strobed while pending, before its grant (5 then 7) → ch2 result uses 7; OVERRUN[2]=1 until RESET.
5. CE held low 10 cycles mid-RUN → result value and channel identical to the CE-always-high run; exactly one OUT_VALID pulse.
6. RESET asserted during RUN → no OUT_VALID; next ch0 sample 1000 → OUT_VALUE=1000 (re-preload).
